uart_tx_serializer: RTL and testbench
=====================================

# uart_tx_serializer

- UART transmitter directly downstream of the FIFO/echo TX arbiter.
- Accepts one byte on a single-cycle start pulse and reports busy from the following cycle.
- Serializes the byte LSB-first as 8N1 (optional even parity) at a fixed baud rate on the PC-facing TX pin.
- Returns to idle with a one-cycle done pulse so the arbiter can issue the next byte.

## Interface
- CLK_FREQ, 100_000_000, system clock frequency in Hz
- BAUD, 9600, line rate in bit/s; DIV = CLK_FREQ/BAUD clocks per bit (integer division, DIV ≥ 2 required)
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high
- i_tx_start  input  1  start request, sampled only in IDLE
- i_tx_data  input  8  byte to send, captured on the cycle i_tx_start is accepted
- o_tx  output  1  serial line, idle high
- o_tx_busy  output  1  high from the cycle after acceptance until frame end
- o_tx_done  output  1  one-cycle pulse at frame end

## Operation
- States: IDLE, START, DATA, PARITY (present only with the macro), STOP.
- IDLE: o_tx=1, busy=0.
  - On i_tx_start=1: latch i_tx_data into the shift register, clear the bit counter and bit index, go to START.
- START: o_tx=0 for DIV clocks, then go to DATA.
- DATA: o_tx = shift[0], held for DIV clocks per bit; shift right after each bit.
  - After bit index 7 completes: go to PARITY if the macro is defined, otherwise STOP.
- PARITY: o_tx = XOR of the 8 latched bits (even parity), held DIV clocks, then STOP.
- STOP: o_tx=1 for DIV clocks.
  - On the last clock: o_tx_done=1 for one cycle; next state IDLE with busy=0.
- i_tx_start outside IDLE is ignored: no queuing, no data capture.
- i_tx_data changes after acceptance have no effect (the arbiter pops its FIFO on the same cycle).
- Bit counter: width $clog2(DIV), counts 0..DIV-1 then wraps to 0. Bit index: 3 bits. No other arithmetic.

## Timing
- Reset values: o_tx=1, o_tx_busy=0, o_tx_done=0, state IDLE, counters 0.
- Reset mid-frame:
  - Aborts at the next edge: o_tx=1, busy=0.
  - No done pulse.
  - A start asserted together with reset is dropped.
- Start accepted at edge k:
  - o_tx=0 and o_tx_busy=1 are visible after edge k (one-cycle latency).
  - The arbiter sees busy on its first post-start cycle.
- Frame length: 10·DIV clocks (11·DIV with parity), measured from edge k.
- o_tx_done and the busy fall occur at the same edge, k+10·DIV (k+11·DIV with parity).
- Back-to-back: a start on the first cycle busy=0 is accepted. There are no mandatory idle cycles beyond the arbiter's own.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- UART_TX_PARITY_EN defined:
  - PARITY state and parity bit are compiled in.
  - Frame is 8E1, 11·DIV clocks.
- UART_TX_PARITY_EN undefined:
  - No PARITY state or XOR logic.
  - Frame is 8N1, 10·DIV clocks.
- Port list is identical in both builds.

## Structure
- Package uart_pkg:
  - state enum typedef (IDLE, START, DATA, PARITY, STOP)
  - UART_DATA_BITS=8
  - line levels UART_IDLE=1, UART_START=0
- Sub-module uart_bit_timer:
  - DIV-cycle counter with clear input and end-of-bit strobe
  - reusable by a future RX block
- Top contains the FSM, shift register, bit index and output registers.

## Test plan
All scenarios use CLK_FREQ=1000, BAUD=100 (DIV=10).
- Reset check: hold reset 3 cycles with i_tx_start=1 → o_tx=1, busy=0, done=0 throughout; no frame starts.
- Single byte: start with 0x55 → busy=1 after the next edge; o_tx shows 0,1,0,1,0,1,0,1,0,1, each level 10 clocks; done pulse and busy fall at edge +100.
- Start while busy: send 0x41, then at +30 pulse start with 0xFF → line carries only the 0x41 frame; no second frame; done pulses once.
- Data hold: start with 0xA5, then drive i_tx_data=0x00 from the next cycle → decoded byte is 0xA5.
- Mid-frame reset: start 0x3C, assert reset at +35 → o_tx=1 and busy=0 after that edge, no done; afterwards a start with 0x0F yields a clean 100-clock frame.
- Parity build (UART_TX_PARITY_EN): send 0x07 → parity bit 1 at clocks 90–99; stop bit at 100–109; done at +110.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding, frame width and line levels
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_e;
    localparam int UART_DATA_BITS = 8;
    localparam logic UART_IDLE = 1'b1;
    localparam logic UART_START = 1'b0;
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: DIV-cycle bit counter with clear input and end-of-bit strobe
module uart_bit_timer #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    output logic o_tick
);
    localparam int W = $clog2(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb begin
        o_tick = cnt_q == LAST;
        cnt_d = (i_clear || o_tick) ? '0 : cnt_q + 1'b1;
    end
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
endmodule

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: LSB-first 8N1 UART transmitter; define UART_TX_PARITY_EN for 8E1
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD = 9600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_tx_start,
    input  logic [7:0] i_tx_data,
    output logic       o_tx,
    output logic       o_tx_busy,
    output logic       o_tx_done
);
    localparam int DIV = CLK_FREQ / BAUD;
    localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);
    uart_state_e state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] idx_q, idx_d;
    logic tx_q, tx_d, busy_q, busy_d, done_q, done_d, tick;
`ifdef UART_TX_PARITY_EN
    logic par_q, par_d;
`endif
    // counter is held at zero while idle so the start bit gets a full DIV clocks
    uart_bit_timer #(.DIV(DIV)) u_timer (
        .clk(clk),
        .reset(reset),
        .i_clear(state_q == IDLE),
        .o_tick(tick)
    );
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d = idx_q;
        tx_d = tx_q;
        busy_d = busy_q;
        done_d = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d = par_q;
`endif
        case (state_q)
            IDLE: if (i_tx_start) begin
                state_d = START;
                shift_d = i_tx_data;
                idx_d = '0;
                tx_d = UART_START;
                busy_d = 1'b1;
`ifdef UART_TX_PARITY_EN
                par_d = ^i_tx_data;
`endif
            end
            START: if (tick) begin
                state_d = DATA;
                tx_d = shift_q[0];
            end
            DATA: if (tick) begin
                if (idx_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                    state_d = PARITY;
                    tx_d = par_q;
`else
                    state_d = STOP;
                    tx_d = UART_IDLE;
`endif
                end else begin
                    shift_d = shift_q >> 1;
                    idx_d = idx_q + 3'd1;
                    tx_d = shift_q[1];
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (tick) begin
                state_d = STOP;
                tx_d = UART_IDLE;
            end
`endif
            STOP: if (tick) begin
                state_d = IDLE;
                busy_d = 1'b0;
                done_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
                tx_d = UART_IDLE;
                busy_d = 1'b0;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q <= '0;
            tx_q <= UART_IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q <= idx_d;
            tx_q <= tx_d;
            busy_q <= busy_d;
            done_q <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q <= par_d;
`endif
        end
    end
    assign o_tx = tx_q;
    assign o_tx_busy = busy_q;
    assign o_tx_done = done_q;
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: directed and random frames checked against a frame-level line model
module tb_uart_tx_serializer;
    localparam int CLK_FREQ = 1000;
    localparam int BAUD = 100;
    localparam int DIV = CLK_FREQ / BAUD;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    logic clk = 1'b0;
    logic reset, i_tx_start, o_tx, o_tx_busy, o_tx_done;
    logic [7:0] i_tx_data;
    int errors = 0;
    int checks = 0;
    always #5 clk = ~clk;
    uart_tx_serializer #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk(clk),
        .reset(reset),
        .i_tx_start(i_tx_start),
        .i_tx_data(i_tx_data),
        .o_tx(o_tx),
        .o_tx_busy(o_tx_busy),
        .o_tx_done(o_tx_done)
    );
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic idle_cycles(input int n, input string tag);
        repeat (n) begin
            @(negedge clk);
            chk({tag, "_tx"}, 8'(o_tx), 8'd1);
            chk({tag, "_busy"}, 8'(o_tx_busy), 8'd0);
            chk({tag, "_done"}, 8'(o_tx_done), 8'd0);
        end
    endtask
    // caller sits on a negedge; frame bit j/DIV is expected on the line after edge k+j
    task automatic run_frame(input logic [7:0] d, input bit hold_zero, input int poke);
        logic fb[NB];
        logic [7:0] dec;
        fb[0] = 1'b0;
        for (int i = 0; i < 8; i++) fb[i+1] = d[i];
`ifdef UART_TX_PARITY_EN
        fb[9] = ^d;
`endif
        fb[NB-1] = 1'b1;
        dec = '0;
        i_tx_start = 1'b1;
        i_tx_data = d;
        @(posedge clk);
        @(negedge clk);
        i_tx_start = 1'b0;
        if (hold_zero) i_tx_data = 8'h00;
        for (int j = 0; j < NB * DIV; j++) begin
            chk("frame_tx", 8'(o_tx), 8'(fb[j/DIV]));
            chk("frame_busy", 8'(o_tx_busy), 8'd1);
            chk("frame_done", 8'(o_tx_done), 8'd0);
            if (j % DIV == DIV / 2 && j / DIV >= 1 && j / DIV <= 8) dec[j/DIV-1] = o_tx;
            i_tx_start = (j == poke);
            if (j == poke) i_tx_data = 8'hFF;
            @(negedge clk);
        end
        chk("decoded", dec, d);
        chk("end_done", 8'(o_tx_done), 8'd1);
        chk("end_busy", 8'(o_tx_busy), 8'd0);
        chk("end_tx", 8'(o_tx), 8'd1);
    endtask
    initial begin
        reset = 1'b1;
        i_tx_start = 1'b1;
        i_tx_data = 8'hAA;
        repeat (3) begin
            @(negedge clk);
            chk("rst_tx", 8'(o_tx), 8'd1);
            chk("rst_busy", 8'(o_tx_busy), 8'd0);
            chk("rst_done", 8'(o_tx_done), 8'd0);
        end
        reset = 1'b0;
        i_tx_start = 1'b0;
        idle_cycles(3, "post_rst");
        run_frame(8'h55, 1'b0, -1);
        idle_cycles(2, "gap55");
        run_frame(8'h41, 1'b0, 30);
        idle_cycles(NB * DIV + 5, "no_second");
        run_frame(8'hA5, 1'b1, -1);
        idle_cycles(1, "gapA5");
        for (int n = 0; n < 4; n++) run_frame(8'($urandom), 1'b0, -1);
        idle_cycles(2, "gaprand");
        i_tx_start = 1'b1;
        i_tx_data = 8'h3C;
        @(posedge clk);
        @(negedge clk);
        i_tx_start = 1'b0;
        repeat (35) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_tx", 8'(o_tx), 8'd1);
        chk("midrst_busy", 8'(o_tx_busy), 8'd0);
        chk("midrst_done", 8'(o_tx_done), 8'd0);
        reset = 1'b0;
        idle_cycles(NB * DIV, "after_midrst");
        run_frame(8'h0F, 1'b0, -1);
        run_frame(8'h07, 1'b0, -1);
        idle_cycles(3, "final");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
